// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the OTTER pipeline datapath (master) and the
// stall/flush/forwarding controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       ID_RS1;
    logic [4:0]       ID_RS2;
    logic             ID_RS1_USED;
    logic             ID_RS2_USED;
    logic [4:0]       EX_RS1;
    logic [4:0]       EX_RS2;
    logic [4:0]       EX_RD;
    logic             EX_MEMREAD;
    logic             EX_BR_TAKEN;
    logic [4:0]       MEM_RD;
    logic             MEM_REGWRITE;
    logic             MEM_MEMREAD;
    logic [4:0]       WB_RD;
    logic             WB_REGWRITE;
    logic             MEM_BUSY;

    logic             PC_EN;
    logic             IF_ID_EN;
    logic             ID_EX_EN;
    logic             EX_MEM_EN;
    logic             MEM_WB_EN;
    logic             IF_ID_NOP;
    logic             ID_EX_NOP;
    logic [1:0]       FWD_A;
    logic [1:0]       FWD_B;
    logic             ID_BYP1;
    logic             ID_BYP2;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] FLUSH_CNT;

    modport master (
        output ID_RS1, ID_RS2, ID_RS1_USED, ID_RS2_USED, EX_RS1, EX_RS2, EX_RD,
               EX_MEMREAD, EX_BR_TAKEN, MEM_RD, MEM_REGWRITE, MEM_MEMREAD,
               WB_RD, WB_REGWRITE, MEM_BUSY,
        input  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_NOP, ID_EX_NOP,
               FWD_A, FWD_B, ID_BYP1, ID_BYP2, STALL_CNT, FLUSH_CNT
    );

    modport slave (
        input  ID_RS1, ID_RS2, ID_RS1_USED, ID_RS2_USED, EX_RS1, EX_RS2, EX_RD,
               EX_MEMREAD, EX_BR_TAKEN, MEM_RD, MEM_REGWRITE, MEM_MEMREAD,
               WB_RD, WB_REGWRITE, MEM_BUSY,
        output PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_NOP, ID_EX_NOP,
               FWD_A, FWD_B, ID_BYP1, ID_BYP2, STALL_CNT, FLUSH_CNT
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage OTTER pipeline: load-use bubbles,
// taken-branch flush window, data-memory freeze, operand forwarding and event counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input logic                  CLK,
    input logic                  RST_N,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {StRun, StFlush, StMemWait} state_t;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [2:0]       FcLoad = 3'(FLUSH_CYCLES - 1);

    state_t           state_q;
    logic   [2:0]     fc_q;
    logic             saved_flush_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic eff_flush;
    logic load_use_raw;
    logic load_use;

    // MEM_WAIT behaves as whichever state it froze once the memory releases.
    assign eff_flush = (state_q == StFlush) || ((state_q == StMemWait) && saved_flush_q);

    assign load_use_raw = hz.EX_MEMREAD && (hz.EX_RD != 5'd0) &&
                          ((hz.ID_RS1_USED && (hz.ID_RS1 == hz.EX_RD)) ||
                           (hz.ID_RS2_USED && (hz.ID_RS2 == hz.EX_RD)));
    assign load_use     = load_use_raw && !eff_flush;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= StRun;
            fc_q          <= 3'd0;
            saved_flush_q <= 1'b0;
            stall_q       <= '0;
            flush_q       <= '0;
        end else if (hz.MEM_BUSY) begin
            state_q       <= StMemWait;
            saved_flush_q <= eff_flush;
            stall_q       <= stall_q + CntOne;
        end else if (hz.EX_BR_TAKEN) begin
            flush_q <= flush_q + CntOne;
            if (FLUSH_CYCLES > 1) begin
                state_q <= StFlush;
                fc_q    <= FcLoad;
            end else begin
                state_q <= StRun;
                fc_q    <= 3'd0;
            end
        end else if (eff_flush) begin
            fc_q    <= fc_q - 3'd1;
            state_q <= (fc_q == 3'd1) ? StRun : StFlush;
        end else begin
            state_q <= StRun;
            if (load_use) begin
                stall_q <= stall_q + CntOne;
            end
        end
    end

    always_comb begin
        hz.PC_EN     = 1'b1;
        hz.IF_ID_EN  = 1'b1;
        hz.ID_EX_EN  = 1'b1;
        hz.EX_MEM_EN = 1'b1;
        hz.MEM_WB_EN = 1'b1;
        hz.IF_ID_NOP = 1'b0;
        hz.ID_EX_NOP = 1'b0;
        if (!RST_N) begin
            hz.PC_EN     = 1'b0;
            hz.IF_ID_EN  = 1'b0;
            hz.ID_EX_EN  = 1'b0;
            hz.EX_MEM_EN = 1'b0;
            hz.MEM_WB_EN = 1'b0;
            hz.IF_ID_NOP = 1'b1;
            hz.ID_EX_NOP = 1'b1;
        end else if (hz.MEM_BUSY) begin
            hz.PC_EN     = 1'b0;
            hz.IF_ID_EN  = 1'b0;
            hz.ID_EX_EN  = 1'b0;
            hz.EX_MEM_EN = 1'b0;
            hz.MEM_WB_EN = 1'b0;
        end else if (hz.EX_BR_TAKEN) begin
            hz.IF_ID_NOP = 1'b1;
            hz.ID_EX_NOP = 1'b1;
        end else if (eff_flush) begin
            hz.IF_ID_NOP = 1'b1;
        end else if (load_use) begin
            hz.PC_EN     = 1'b0;
            hz.IF_ID_EN  = 1'b0;
            hz.ID_EX_NOP = 1'b1;
        end
    end

    // A load still in MEM has no result yet, so it never forwards from EX/MEM.
    always_comb begin
        hz.FWD_A   = 2'b00;
        hz.FWD_B   = 2'b00;
        hz.ID_BYP1 = 1'b0;
        hz.ID_BYP2 = 1'b0;
        if (RST_N) begin
            if (hz.MEM_REGWRITE && !hz.MEM_MEMREAD && (hz.MEM_RD != 5'd0) &&
                (hz.MEM_RD == hz.EX_RS1)) begin
                hz.FWD_A = 2'b01;
            end else if (hz.WB_REGWRITE && (hz.WB_RD != 5'd0) && (hz.WB_RD == hz.EX_RS1)) begin
                hz.FWD_A = 2'b10;
            end
            if (hz.MEM_REGWRITE && !hz.MEM_MEMREAD && (hz.MEM_RD != 5'd0) &&
                (hz.MEM_RD == hz.EX_RS2)) begin
                hz.FWD_B = 2'b01;
            end else if (hz.WB_REGWRITE && (hz.WB_RD != 5'd0) && (hz.WB_RD == hz.EX_RS2)) begin
                hz.FWD_B = 2'b10;
            end
            hz.ID_BYP1 = hz.WB_REGWRITE && (hz.WB_RD != 5'd0) && (hz.WB_RD == hz.ID_RS1);
            hz.ID_BYP2 = hz.WB_REGWRITE && (hz.WB_RD != 5'd0) && (hz.WB_RD == hz.ID_RS2);
        end
    end

    assign hz.STALL_CNT = stall_q;
    assign hz.FLUSH_CNT = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2): reset, load-use, branch flush,
// memory freeze inside a flush, priority interactions, forwarding and ID bypass.
module tb_pipeline_hazard_ctrl;
    logic CLK;
    logic RST_N;
    int   n_chk;
    int   n_err;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) hz ();

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES(2),
        .CNT_W       (32)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .hz   (hz.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN}
    task automatic chk_en(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, hz.PC_EN, hz.IF_ID_EN, hz.ID_EX_EN, hz.EX_MEM_EN, hz.MEM_WB_EN},
            {27'd0, exp});
    endtask

    // {IF_ID_NOP, ID_EX_NOP}
    task automatic chk_nop(input string tag, input logic [1:0] exp);
        chk(tag, {30'd0, hz.IF_ID_NOP, hz.ID_EX_NOP}, {30'd0, exp});
    endtask

    task automatic idle();
        hz.ID_RS1 = 5'd0; hz.ID_RS2 = 5'd0; hz.ID_RS1_USED = 1'b0; hz.ID_RS2_USED = 1'b0;
        hz.EX_RS1 = 5'd0; hz.EX_RS2 = 5'd0; hz.EX_RD = 5'd0; hz.EX_MEMREAD = 1'b0;
        hz.EX_BR_TAKEN = 1'b0; hz.MEM_RD = 5'd0; hz.MEM_REGWRITE = 1'b0;
        hz.MEM_MEMREAD = 1'b0; hz.WB_RD = 5'd0; hz.WB_REGWRITE = 1'b0; hz.MEM_BUSY = 1'b0;
    endtask

    task automatic load_use_vec();
        hz.EX_MEMREAD = 1'b1; hz.EX_RD = 5'd5; hz.ID_RS1 = 5'd5; hz.ID_RS1_USED = 1'b1;
    endtask

    // Advance one clock edge; inputs for the next cycle are applied after the negedge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        RST_N = 1'b0;
        idle();
        @(negedge CLK);

        // Reset: outputs forced even with a forwarding match present
        hz.MEM_RD = 5'd7; hz.MEM_REGWRITE = 1'b1; hz.EX_RS1 = 5'd7;
        hz.WB_RD = 5'd7; hz.WB_REGWRITE = 1'b1; hz.ID_RS1 = 5'd7;
        #1;
        chk_en("rst_en", 5'b00000);
        chk_nop("rst_nop", 2'b11);
        chk("rst_fwd_a", {30'd0, hz.FWD_A}, 32'd0);
        chk("rst_byp1", {31'd0, hz.ID_BYP1}, 32'd0);
        step();
        RST_N = 1'b1;
        idle();
        #1;
        chk_en("run_en", 5'b11111);
        chk_nop("run_nop", 2'b00);
        chk("rst_stall_cnt", hz.STALL_CNT, 32'd0);
        chk("rst_flush_cnt", hz.FLUSH_CNT, 32'd0);

        // Load-use on RS1: one bubble
        load_use_vec();
        #1;
        chk_en("lu_en", 5'b00111);
        chk_nop("lu_nop", 2'b01);
        step();
        idle();
        hz.MEM_RD = 5'd5; hz.MEM_MEMREAD = 1'b1; hz.MEM_REGWRITE = 1'b1;
        hz.ID_RS1 = 5'd5; hz.ID_RS1_USED = 1'b1;
        #1;
        chk_en("lu_after_en", 5'b11111);
        chk_nop("lu_after_nop", 2'b00);
        chk("lu_stall_cnt", hz.STALL_CNT, 32'd1);

        // Matching RS2 that is not read: no stall
        idle();
        hz.EX_MEMREAD = 1'b1; hz.EX_RD = 5'd5; hz.ID_RS2 = 5'd5; hz.ID_RS2_USED = 1'b0;
        #1;
        chk_en("lu_unused_en", 5'b11111);
        step();

        // Taken branch, then one flush cycle with load-use suppressed
        idle();
        hz.EX_BR_TAKEN = 1'b1;
        #1;
        chk_en("br_en", 5'b11111);
        chk_nop("br_nop", 2'b11);
        step();
        idle();
        load_use_vec();
        #1;
        chk_nop("flush_nop", 2'b10);
        chk_en("flush_en", 5'b11111);
        chk("br_flush_cnt", hz.FLUSH_CNT, 32'd1);
        step();
        idle();
        #1;
        chk_nop("post_flush_nop", 2'b00);
        chk("flush_stall_cnt", hz.STALL_CNT, 32'd1);

        // Branch, then MEM_BUSY for three cycles inside the flush window
        hz.EX_BR_TAKEN = 1'b1;
        step();
        idle();
        hz.MEM_BUSY = 1'b1;
        #1;
        chk_en("busy1_en", 5'b00000);
        chk_nop("busy1_nop", 2'b00);
        step();
        #1;
        chk_en("busy2_en", 5'b00000);
        step();
        #1;
        chk_en("busy3_en", 5'b00000);
        step();
        hz.MEM_BUSY = 1'b0;
        #1;
        chk_nop("resume_flush_nop", 2'b10);
        chk_en("resume_flush_en", 5'b11111);
        step();
        #1;
        chk_nop("resume_run_nop", 2'b00);
        chk("busy_stall_cnt", hz.STALL_CNT, 32'd4);
        chk("busy_flush_cnt", hz.FLUSH_CNT, 32'd2);

        // MEM_BUSY during load-use: freeze first, bubble on the first free cycle
        load_use_vec();
        hz.MEM_BUSY = 1'b1;
        #1;
        chk_en("lu_busy_en", 5'b00000);
        chk_nop("lu_busy_nop", 2'b00);
        step();
        hz.MEM_BUSY = 1'b0;
        #1;
        chk_en("lu_late_en", 5'b00111);
        chk_nop("lu_late_nop", 2'b01);
        step();
        idle();
        #1;
        chk("lu_busy_stall_cnt", hz.STALL_CNT, 32'd6);

        // Branch together with load-use: branch wins, no stall counted
        load_use_vec();
        hz.EX_BR_TAKEN = 1'b1;
        #1;
        chk_nop("br_lu_nop", 2'b11);
        chk("br_lu_pc_en", {31'd0, hz.PC_EN}, 32'd1);
        step();
        idle();
        #1;
        chk("br_lu_stall_cnt", hz.STALL_CNT, 32'd6);
        chk("br_lu_flush_cnt", hz.FLUSH_CNT, 32'd3);
        chk_nop("br_lu_flush_nop", 2'b10);

        // Reset in the middle of the flush window
        RST_N = 1'b0;
        #1;
        chk_en("rst_mid_en", 5'b00000);
        step();
        RST_N = 1'b1;
        #1;
        chk_en("rst_mid_run_en", 5'b11111);
        chk_nop("rst_mid_run_nop", 2'b00);
        chk("rst_mid_stall_cnt", hz.STALL_CNT, 32'd0);
        chk("rst_mid_flush_cnt", hz.FLUSH_CNT, 32'd0);

        // Forwarding priority and ID bypass
        hz.MEM_RD = 5'd7; hz.WB_RD = 5'd7; hz.EX_RS1 = 5'd7;
        hz.MEM_REGWRITE = 1'b1; hz.WB_REGWRITE = 1'b1; hz.MEM_MEMREAD = 1'b0;
        #1;
        chk("fwd_a_mem", {30'd0, hz.FWD_A}, 32'd1);
        hz.MEM_RD = 5'd0;
        #1;
        chk("fwd_a_wb", {30'd0, hz.FWD_A}, 32'd2);
        hz.EX_RS1 = 5'd0;
        #1;
        chk("fwd_a_x0", {30'd0, hz.FWD_A}, 32'd0);
        hz.MEM_RD = 5'd7; hz.MEM_MEMREAD = 1'b1; hz.EX_RS2 = 5'd7;
        #1;
        chk("fwd_b_load_in_mem", {30'd0, hz.FWD_B}, 32'd2);
        hz.MEM_MEMREAD = 1'b0; hz.WB_RD = 5'd3;
        #1;
        chk("fwd_b_mem", {30'd0, hz.FWD_B}, 32'd1);
        hz.WB_RD = 5'd9; hz.ID_RS1 = 5'd9; hz.ID_RS2 = 5'd3;
        #1;
        chk("byp1", {31'd0, hz.ID_BYP1}, 32'd1);
        chk("byp2", {31'd0, hz.ID_BYP2}, 32'd0);
        hz.WB_REGWRITE = 1'b0;
        #1;
        chk("byp1_nowrite", {31'd0, hz.ID_BYP1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
